lsu_mem: RTL and testbench
==========================

LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter XLEN, default 32, meaning data/address width; legal values are 32 and 64.
REQ-002 Parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for bus_ack_i before aborting; legal range is 1..255.
REQ-003 Parameter HALT_ADDR, default `HALT_ADDR, meaning the ISA-test halt address.
REQ-004 clk_i  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 stall_i  in  1  pipeline hold from pipectrl.
REQ-007 rd_addr_i/rd_we_i  in  5/1  destination register and write enable from exe.
REQ-008 rd_data_i  in  XLEN  ALU result, or store data when mem_we_i=1.
REQ-009 mem_addr_i  in  XLEN  byte address; mem_re_i/mem_we_i  in  1/1  load/store strobe; opfunc3_i  in  3  access type.
REQ-010 bus_req_o/bus_we_o  out  1/1  request and write qualifier; bus_addr_o  out  XLEN  word-aligned address (low log2(XLEN/8) bits zero).
REQ-011 bus_be_o  out  XLEN/8  byte enables; bus_wdata_o  out  XLEN  lane-shifted store data.
REQ-012 bus_ack_i  in  1  one-cycle completion; bus_rdata_i  in  XLEN  read data, valid when bus_ack_i=1.
REQ-013 stall_req_o  out  1  hold request to pipectrl.
REQ-014 rd_addr_o/rd_data_o/rd_we_o  out  5/XLEN/1  to writeback and forwarding.
REQ-015 bus_err_o  out  1  one-cycle timeout pulse; halt_o  out  1  sticky ISA-test halt.

Function
REQ-016 The FSM SHALL have the states IDLE and BUSY.
- IDLE->BUSY when (mem_re_i|mem_we_i) & !stall_i & access legal.
- BUSY->IDLE on bus_ack_i or on timeout.
REQ-017 On the IDLE->BUSY edge, bus_req_o, bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o SHALL be registered; they SHALL be held stable while in BUSY and deasserted in the cycle after ack or timeout.
REQ-018 stall_req_o SHALL be combinational and equal to (IDLE & legal memory op & !stall_i) | (BUSY & !bus_ack_i & !timeout).
REQ-019 Minimum load/store latency SHALL be 2 cycles: op presented in cycle N, request in N+1, ack in N+1 at earliest, result registered at end of N+1.
REQ-020 Access types:
- LB/LBU=000/100, LH/LHU=001/101, LW=010, LWU=110 (XLEN=64 only), LD=011 (XLEN=64 only).
- Stores use SB/SH/SW/SD = 000/001/010/011.
- Any other code SHALL be treated as illegal.
REQ-021 Byte enables SHALL select exactly the accessed lanes: B=1 lane, H=2, W=4, D=8.
REQ-022 Store data SHALL be replicated/shifted into the addressed lanes; no read-modify-write.
REQ-023 Load data SHALL be extracted from the addressed lanes, sign-extended for B/H/W and zero-extended for BU/HU/WU.
REQ-024 A non-memory op SHALL pass through with zero wait: rd_*_o <= rd_*_i when !stall_i.
REQ-025 With stall_i=1 and state IDLE, rd_*_o SHALL hold and no request SHALL issue.
REQ-026 With stall_i=1 and state BUSY, the transaction SHALL continue; its result SHALL be captured and held until stall_i drops.
REQ-027 rd_we_o SHALL be 1 for a completed load and 0 for stores, aborted accesses and illegal accesses.
REQ-028 A timer SHALL count cycles in BUSY; at count==TIMEOUT without ack, the block SHALL:
- pulse bus_err_o,
- return to IDLE,
- write rd_data_o=0 with rd_we_o=0.
REQ-029 An ack coinciding with the timeout cycle SHALL win: the transaction completes normally and bus_err_o stays 0.
REQ-030 bus_ack_i while in IDLE SHALL be ignored.
REQ-031 halt_o SHALL set when an SW to HALT_ADDR completes, and SHALL remain set until reset.

Reset
REQ-032 When rst_i=1 at a clock edge:
- state=IDLE;
- all outputs=0 (bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, rd_addr_o, rd_data_o, rd_we_o, bus_err_o, halt_o);
- timer=0.
REQ-033 Reset while in BUSY SHALL abandon the transaction without a writeback or error pulse.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN defined: a misaligned access (H not 2-aligned, W not 4-aligned, D not 8-aligned) or illegal opfunc3_i SHALL:
- issue no bus request,
- pulse output misalign_o (1 bit) for one cycle,
- write rd_we_o=0.
REQ-035 Macro absent: misalign_o SHALL not exist.
- Misaligned accesses SHALL be forced aligned by clearing the low address bits for lane selection.
- Illegal codes SHALL complete as no-ops without a bus request.

Verification
REQ-036 LB at addr 0x103, ack after 3 cycles with bus_rdata_i=0x80FF_FFFF -> bus_be_o=1000, rd_data_o=0xFFFF_FF80, stall_req_o high for 4 cycles.
REQ-037 SH at 0x202 with rd_data_i=0x1234_ABCD -> bus_addr_o=0x200, bus_be_o=1100, bus_wdata_o=0xABCD_ABCD, rd_we_o=0.
REQ-038 LW with no ack, TIMEOUT=4 -> bus_err_o pulse in the 4th BUSY cycle, then IDLE, rd_we_o=0.
REQ-039 LHU at 0x101 -> with the macro: misalign_o=1 and no bus_req_o; without the macro: address 0x100 is used and the result is zero-extended.
REQ-040 stall_i held high across the ack of an LW returning 0xDEAD_BEEF -> rd_data_o updates only after stall_i falls; reset asserted mid-BUSY -> all outputs 0 next cycle.
REQ-041 SW to HALT_ADDR -> halt_o=1 after ack and sticky until rst_i.

Source files
------------

// File: rtl/lsu_mem.sv
// lsu_mem: memory stage, single-outstanding bus access with timeout and halt.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned/illegal accesses on misalign_o.
`ifndef HALT_ADDR
`define HALT_ADDR 'h0000_1000
`endif

module lsu_mem #(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 16,
  parameter logic [XLEN-1:0] HALT_ADDR = `HALT_ADDR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_we_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [2:0]        opfunc3_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_addr_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [XLEN-1:0]   bus_rdata_i,
  output logic              stall_req_o,
  output logic [4:0]        rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              rd_we_o,
  output logic              bus_err_o,
  output logic              halt_o
`ifdef LSU_MISALIGN_TRAP_EN
  , output logic            misalign_o
`endif
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;

  logic            memop, code_ok, legal;
  logic            start, done, timeout, busy;
  logic [1:0]      sz;
  logic [OW-1:0]   lowm, off;
  logic [NB-1:0]   bmask, be_n;
  logic [XLEN-1:0] wdata_n, sh, ld_data;
  logic            res_we;
  logic [XLEN-1:0] res_data;

  logic [7:0]      timer_q;
  logic [2:0]      f3_q;
  logic [OW-1:0]   off_q;
  logic            ld_q, halt_hit_q;
  logic [4:0]      rda_q;
  logic            pend_v, pend_we;
  logic [XLEN-1:0] pend_data;

  assign busy = (state_q == BUSY);

  always_comb begin
    memop = mem_re_i | mem_we_i;
    sz = opfunc3_i[1:0];
    if (mem_we_i)
      code_ok = !opfunc3_i[2] && (sz != 2'd3 || XLEN == 64);
    else
      code_ok = (opfunc3_i != 3'b111) &&
                (XLEN == 64 || (sz != 2'd3 && opfunc3_i != 3'b110));
    unique case (sz)
      2'd0: begin
        lowm = OW'(0);
        bmask = NB'(1);
        wdata_n = {NB{rd_data_i[7:0]}};
      end
      2'd1: begin
        lowm = OW'(1);
        bmask = NB'(3);
        wdata_n = {(NB/2){rd_data_i[15:0]}};
      end
      2'd2: begin
        lowm = OW'(3);
        bmask = NB'(15);
        wdata_n = {(NB/4){rd_data_i[31:0]}};
      end
      default: begin
        lowm = OW'(7);
        bmask = NB'(255);
        wdata_n = rd_data_i;
      end
    endcase
    // misaligned lanes are forced down to the natural boundary
    off = mem_addr_i[OW-1:0] & ~lowm;
    be_n = bmask << off;
`ifdef LSU_MISALIGN_TRAP_EN
    legal = code_ok && !(|(mem_addr_i[OW-1:0] & lowm));
`else
    legal = code_ok;
`endif
  end

  always_comb begin
    sh = bus_rdata_i >> {off_q, 3'b000};
    unique case (f3_q)
      3'b000:  ld_data = XLEN'($signed(sh[7:0]));
      3'b100:  ld_data = XLEN'(sh[7:0]);
      3'b001:  ld_data = XLEN'($signed(sh[15:0]));
      3'b101:  ld_data = XLEN'(sh[15:0]);
      3'b010:  ld_data = XLEN'($signed(sh[31:0]));
      3'b110:  ld_data = XLEN'(sh[31:0]);
      default: ld_data = sh;
    endcase
    res_we = bus_ack_i & ld_q;
    res_data = res_we ? ld_data : '0;
  end

  always_comb begin
    state_d = state_q;
    start = 1'b0;
    done = 1'b0;
    timeout = 1'b0;
    stall_req_o = 1'b0;
    bus_err_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // pend_v: the held op already finished under stall
        start = memop & legal & !stall_i & !pend_v;
        stall_req_o = start;
        if (start) state_d = BUSY;
      end
      BUSY: begin
        timeout = (timer_q == 8'(TIMEOUT - 1));
        done = bus_ack_i | timeout;
        bus_err_o = timeout & !bus_ack_i;
        stall_req_o = !done;
        if (done) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_addr_o <= '0;
      bus_be_o <= '0;
      bus_wdata_o <= '0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
      rd_we_o <= 1'b0;
      halt_o <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      ld_q <= 1'b0;
      halt_hit_q <= 1'b0;
      rda_q <= '0;
      pend_v <= 1'b0;
      pend_we <= 1'b0;
      pend_data <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= (busy && !done) ? timer_q + 8'd1 : '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
      if (start) begin
        bus_req_o <= 1'b1;
        bus_we_o <= mem_we_i;
        bus_addr_o <= {mem_addr_i[XLEN-1:OW], {OW{1'b0}}};
        bus_be_o <= be_n;
        bus_wdata_o <= mem_we_i ? wdata_n : '0;
        f3_q <= opfunc3_i;
        off_q <= off;
        ld_q <= !mem_we_i;
        halt_hit_q <= mem_we_i && opfunc3_i == 3'b010 &&
                      mem_addr_i == HALT_ADDR;
        rda_q <= rd_addr_i;
        rd_we_o <= 1'b0;
      end else if (done) begin
        bus_req_o <= 1'b0;
        bus_we_o <= 1'b0;
        bus_addr_o <= '0;
        bus_be_o <= '0;
        bus_wdata_o <= '0;
        if (bus_ack_i && halt_hit_q) halt_o <= 1'b1;
        if (stall_i) begin
          pend_v <= 1'b1;
          pend_we <= res_we;
          pend_data <= res_data;
        end else begin
          rd_addr_o <= rda_q;
          rd_we_o <= res_we;
          rd_data_o <= res_data;
        end
      end else if (!busy && !stall_i) begin
        if (pend_v) begin
          pend_v <= 1'b0;
          rd_addr_o <= rda_q;
          rd_we_o <= pend_we;
          rd_data_o <= pend_data;
        end else if (memop) begin
          rd_addr_o <= rd_addr_i;
          rd_we_o <= 1'b0;
          rd_data_o <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_o <= 1'b1;
`endif
        end else begin
          rd_addr_o <= rd_addr_i;
          rd_we_o <= rd_we_i;
          rd_data_o <= rd_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed + random checks of lsu_mem against a byte-lane model.
// Covers loads/stores, timeout, stall hold, halt and reset.
module tb_lsu_mem;

  localparam int TO = 4;
  localparam logic [31:0] HADDR = 32'h0000_0ffc;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i;
  logic [4:0]  rd_addr_i, rd_addr_o;
  logic        rd_we_i, rd_we_o;
  logic [31:0] rd_data_i, rd_data_o;
  logic [31:0] mem_addr_i;
  logic        mem_re_i, mem_we_i;
  logic [2:0]  opfunc3_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i, stall_req_o, bus_err_o, halt_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0]  m_rd_addr;
  logic        m_rd_we, m_halt;
  logic [31:0] m_rd_data;

  lsu_mem #(
    .XLEN(32),
    .TIMEOUT(TO),
    .HALT_ADDR(HADDR)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .stall_i(stall_i),
    .rd_addr_i(rd_addr_i),
    .rd_we_i(rd_we_i),
    .rd_data_i(rd_data_i),
    .mem_addr_i(mem_addr_i),
    .mem_re_i(mem_re_i),
    .mem_we_i(mem_we_i),
    .opfunc3_i(opfunc3_i),
    .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i),
    .stall_req_o(stall_req_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o),
    .rd_we_o(rd_we_o),
    .bus_err_o(bus_err_o),
    .halt_o(halt_o)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int m_n(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] f3,
                                 input logic [31:0] a);
    bit ok;
    if (we) ok = f3 inside {3'd0, 3'd1, 3'd2};
    else ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (TRAP && (a % m_n(f3)) != 0) ok = 1'b0;
    return ok;
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
    int n = m_n(f3);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    logic [3:0] be = '0;
    for (int i = 0; i < m_n(f3); i++) be[m_off(f3, a) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d,
                                          input logic [2:0] f3);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = d[8*(j % m_n(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] r,
                                         input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] v = '0;
    int n = m_n(f3);
    int o = m_off(f3, a);
    for (int i = 0; i < n; i++) v[8*i +: 8] = r[8*(o + i) +: 8];
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8*n));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag);
    chk({tag, "_rd_addr"}, rd_addr_o, m_rd_addr);
    chk({tag, "_rd_we"}, rd_we_o, m_rd_we);
    chk({tag, "_rd_data"}, rd_data_o, m_rd_data);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic bubble;
    mem_re_i = 1'b0;
    mem_we_i = 1'b0;
    rd_we_i = 1'b0;
    stall_i = 1'b0;
    bus_ack_i = 1'b0;
  endtask

  task automatic model_reset;
    m_rd_addr = '0;
    m_rd_we = 1'b0;
    m_rd_data = '0;
    m_halt = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, bus_req_o, 0);
    chk({tag, "_we"}, bus_we_o, 0);
    chk({tag, "_addr"}, bus_addr_o, 0);
    chk({tag, "_be"}, bus_be_o, 0);
    chk({tag, "_wdata"}, bus_wdata_o, 0);
    chk({tag, "_err"}, bus_err_o, 0);
    chk({tag, "_halt"}, halt_o, 0);
    chk_rd(tag);
  endtask

  task automatic nop(input logic [4:0] rda, input logic [31:0] d,
                     input bit w, input bit st, input bit ack);
    mem_re_i = 1'b0;
    mem_we_i = 1'b0;
    rd_addr_i = rda;
    rd_data_i = d;
    rd_we_i = w;
    stall_i = st;
    bus_ack_i = ack;
    #1;
    chk("nop_stall_req", stall_req_o, 0);
    tick;
    chk("nop_req", bus_req_o, 0);
    if (!st) begin
      m_rd_addr = rda;
      m_rd_we = w;
      m_rd_data = d;
    end
    chk_rd("nop");
    bubble;
  endtask

  task automatic mem_op(input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rda, input int dly,
                        input logic [31:0] rdat, input bit sa,
                        output int nst);
    bit lg, ack, last;
    logic [31:0] res;
    nst = 0;
    ack = 1'b0;
    mem_re_i = !we;
    mem_we_i = we;
    opfunc3_i = f3;
    mem_addr_i = a;
    rd_data_i = d;
    rd_addr_i = rda;
    rd_we_i = !we;
    stall_i = 1'b0;
    bus_ack_i = 1'b0;
    lg = m_legal(we, f3, a);
    #1;
    chk("idle_stall_req", stall_req_o, lg);
    if (stall_req_o) nst++;
    if (!lg) begin
      tick;
      chk("ill_req", bus_req_o, 0);
      m_rd_addr = rda;
      m_rd_we = 1'b0;
      m_rd_data = '0;
      chk_rd("ill");
`ifdef LSU_MISALIGN_TRAP_EN
      chk("ill_misalign", misalign_o, 1);
`endif
      bubble;
      return;
    end
    tick;
    m_rd_we = 1'b0;
    chk("req", bus_req_o, 1);
    chk("bus_we", bus_we_o, we);
    chk("bus_addr", bus_addr_o, (a / 4) * 4);
    chk("bus_be", bus_be_o, m_be(f3, a));
    if (we) chk("bus_wdata", bus_wdata_o, m_wdata(d, f3));
    for (int c = 1; c <= TO; c++) begin
      ack = (c == dly);
      last = ack || (c == TO);
      if (ack) begin
        bus_ack_i = 1'b1;
        bus_rdata_i = rdat;
        stall_i = sa;
      end
      #1;
      chk("bus_err", bus_err_o, (c == TO) && !ack);
      chk("busy_stall_req", stall_req_o, !last);
      if (stall_req_o) nst++;
      if (last) break;
      tick;
      chk("hold_req", bus_req_o, 1);
      chk("hold_be", bus_be_o, m_be(f3, a));
    end
    tick;
    bus_ack_i = 1'b0;
    chk("req_drop", bus_req_o, 0);
    chk("err_drop", bus_err_o, 0);
    res = (ack && !we) ? m_load(rdat, f3, a) : 32'h0;
    if (ack && we && f3 == 3'd2 && a == HADDR) m_halt = 1'b1;
    if (ack && sa) begin
      chk_rd("stall_hold");
      tick;
      chk_rd("stall_hold2");
      stall_i = 1'b0;
      #1;
      chk("pend_stall_req", stall_req_o, 0);
      tick;
      chk("pend_req", bus_req_o, 0);
    end
    m_rd_addr = rda;
    m_rd_we = ack && !we;
    m_rd_data = res;
    chk_rd("done");
    chk("halt", halt_o, m_halt);
    bubble;
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    rd_addr_i = '0;
    rd_data_i = '0;
    mem_addr_i = '0;
    opfunc3_i = '0;
    bus_rdata_i = '0;
    bubble;
    model_reset;
    tick;
    tick;
    rst_i = 1'b0;
    chk_zero("reset");
    chk("reset_stall_req", stall_req_o, 0);

    nop(5'd5, 32'h1111_2222, 1'b1, 1'b0, 1'b0);
    nop(5'd6, 32'h3333_4444, 1'b1, 1'b1, 1'b0);
    nop(5'd7, 32'h5555_6666, 1'b1, 1'b0, 1'b1);

    mem_re_i = 1'b1;
    opfunc3_i = 3'b010;
    mem_addr_i = 32'h40;
    rd_addr_i = 5'd9;
    stall_i = 1'b1;
    #1;
    chk("idle_stall_noreq", stall_req_o, 0);
    tick;
    chk("idle_stall_req", bus_req_o, 0);
    chk_rd("idle_stall");
    bubble;

    mem_op(0, 3'b000, 32'h103, 0, 5'd3, 4, 32'h80FF_FFFF, 0, n);
    chk("lb_data", rd_data_o, 32'hFFFF_FF80);
    chk("lb_stall_cycles", n, 4);

    mem_op(1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd4, 2, 0, 0, n);
    chk("sh_rd_we", rd_we_o, 0);

    mem_op(0, 3'b010, 32'h44, 0, 5'd8, 99, 0, 0, n);
    chk("timeout_rd_we", rd_we_o, 0);
    chk("timeout_stall_cycles", n, TO);

    mem_op(0, 3'b010, 32'h48, 0, 5'd10, TO, 32'h0BAD_F00D, 0, n);
    chk("ack_wins_data", rd_data_o, 32'h0BAD_F00D);

    mem_op(0, 3'b101, 32'h101, 0, 5'd11, 1, 32'h5566_8899, 0, n);
    if (TRAP) chk("lhu_mis_we", rd_we_o, 0);
    else chk("lhu_data", rd_data_o, 32'h0000_8899);

    mem_op(0, 3'b010, 32'h80, 0, 5'd12, 2, 32'hDEAD_BEEF, 1, n);
    chk("stall_lw_data", rd_data_o, 32'hDEAD_BEEF);

    mem_op(0, 3'b111, 32'h84, 0, 5'd13, 1, 0, 0, n);

    mem_op(1, 3'b010, HADDR, 32'h1, 5'd0, 1, 0, 0, n);
    chk("halt_set", halt_o, 1);
    nop(5'd1, 32'h7, 1'b1, 1'b0, 1'b0);
    chk("halt_sticky", halt_o, 1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        nop(5'($urandom), $urandom, 1'($urandom),
            1'($urandom), 1'($urandom));
      end else begin
        mem_op(1'($urandom), 3'($urandom), $urandom & 32'hfff,
               $urandom, 5'($urandom), $urandom_range(1, 6),
               $urandom, $urandom_range(0, 3) == 0, n);
      end
    end

    mem_re_i = 1'b1;
    opfunc3_i = 3'b010;
    mem_addr_i = 32'h90;
    rd_addr_i = 5'd14;
    #1;
    tick;
    chk("midbusy_req", bus_req_o, 1);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    bubble;
    model_reset;
    chk_zero("midbusy_reset");
    tick;
    chk("post_reset_req", bus_req_o, 0);
    chk("post_reset_we", rd_we_o, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
